// File: rtl/multiplicador_secuencial.sv
// Sequential signed fixed-point multiplier: one radix-2 shift-add step per cycle on the
// operand magnitudes, sign applied at the end, with saturation of the single overflow case.
module multiplicador_secuencial #(
    parameter int cant_bits = 25,
    parameter int ent       = 10,
    parameter int frac      = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [cant_bits-1:0]      a,
    input  logic [cant_bits-1:0]      b,
    output logic [2*ent+2*frac:0]     producto,
    output logic                      done,
    output logic                      busy
);

    localparam int PW = 2*ent + 2*frac + 1;
    localparam int AW = 2*cant_bits;
    localparam int CW = $clog2(cant_bits + 1);

    localparam logic [AW-1:0] MAX_POS = {{(AW-PW+1){1'b0}}, {(PW-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         cnt;
    logic [AW-1:0]         mcand;
    logic [cant_bits-1:0]  mplier;
    logic [AW-1:0]         acc;
    logic                  neg;

    logic [cant_bits-1:0]  a_mag;
    logic [cant_bits-1:0]  b_mag;
    logic [AW-1:0]         acc_sum;
    logic [AW-1:0]         acc_signed;
    logic [PW-1:0]         result;
    logic                  last;

    // Magnitudes fit in cant_bits unsigned bits, including the most negative operand.
    assign a_mag = a[cant_bits-1] ? (~a + cant_bits'(1)) : a;
    assign b_mag = b[cant_bits-1] ? (~b + cant_bits'(1)) : b;

    assign acc_sum    = acc + (mplier[0] ? mcand : '0);
    assign acc_signed = neg ? (~acc_sum + AW'(1)) : acc_sum;
    assign last       = (cnt == CW'(cant_bits - 1));

    // Only min*min exceeds the positive range; it clamps to the largest representable value.
    always_comb begin
        result = acc_signed[PW-1:0];
        if (!neg && (acc_sum > MAX_POS)) begin
            result = MAX_POS[PW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            producto <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{cant_bits{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= a[cant_bits-1] ^ b[cant_bits-1];
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        producto <= result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Self-checking bench for multiplicador_secuencial: directed corner cases, reset abort,
// back-to-back operation and randomized operands against an arithmetic reference product.
module tb_multiplicador_secuencial;

    localparam int CB  = 25;
    localparam int ENT = 10;
    localparam int FRC = 14;
    localparam int PW  = 2*ENT + 2*FRC + 1;
    localparam int LAT = CB;

    localparam logic [CB-1:0] MINV = {1'b1, {(CB-1){1'b0}}};
    localparam logic [CB-1:0] MAXV = {1'b0, {(CB-1){1'b1}}};

    logic          clk;
    logic          reset;
    logic          start;
    logic [CB-1:0] a;
    logic [CB-1:0] b;
    logic [PW-1:0] producto;
    logic          done;
    logic          busy;

    logic [PW-1:0] exp_q[$];
    int            n_tests;
    int            n_fail;
    int            cyc;

    multiplicador_secuencial #(.cant_bits(CB), .ent(ENT), .frac(FRC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .producto (producto),
        .done     (done),
        .busy     (busy)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, want summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact signed product, clamped to the positive limit of the output format.
    function automatic logic [PW-1:0] ref_mul(input logic [CB-1:0] x, input logic [CB-1:0] y);
        longint p;
        longint lim;
        logic [63:0] pv;
        lim = (longint'(1) <<< (PW-1)) - 1;
        p   = longint'($signed(x)) * longint'($signed(y));
        if (p > lim) p = lim;
        pv = p;
        return pv[PW-1:0];
    endfunction

    function automatic logic [CB-1:0] pick();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return MINV;
            2:       return MAXV;
            3:       return CB'(1);
            4:       return '1;
            default: return CB'($urandom);
        endcase
    endfunction

    // driver tasks: caller is in the low clock phase; start is taken at the next edge
    task automatic issue(input logic [CB-1:0] op_a, input logic [CB-1:0] op_b,
                         input logic [PW-1:0] exp, input bit keep_start);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
        exp_q.push_back(exp);
    endtask

    task automatic wait_done(output int lat, output int busy_n, input bit poke_start);
        lat    = -1;
        busy_n = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = n;
                break;
            end
            a = CB'($urandom);
            b = CB'($urandom);
            if (poke_start) start = (n < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    // scoreboard: compare against the expected queue, then confirm the pulse ends and output holds
    task automatic finish_op(input string tag, input int lat, input int busy_n);
        logic [PW-1:0] exp;
        logic [PW-1:0] held;
        exp = '0;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(LAT + 1));
        check({tag, "_producto"}, 64'(producto), 64'(exp));
        held = producto;
        @(negedge clk);
        check({tag, "_done_pulse_end"}, 64'({done, busy}), 64'(0));
        check({tag, "_producto_hold"}, 64'(producto), 64'(exp));
        if (producto !== held) check({tag, "_producto_stable"}, 64'(producto), 64'(held));
    endtask

    task automatic run_op(input logic [CB-1:0] op_a, input logic [CB-1:0] op_b,
                          input logic [PW-1:0] exp, input string tag);
        int lat;
        int busy_n;
        issue(op_a, op_b, exp, 1'b0);
        wait_done(lat, busy_n, 1'b1);
        start = 1'b0;
        finish_op(tag, lat, busy_n);
    endtask

    initial begin
        int            lat;
        int            busy_n;
        int            done_n;
        int            last_done;
        logic [CB-1:0] ra;
        logic [CB-1:0] rb;
        logic [PW-1:0] prev;

        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b1;
        a       = MAXV;
        b       = MAXV;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({producto, done, busy}), 64'(0));

        // start accepted on the very first edge with reset low
        reset = 1'b0;
        run_op(25'h004000, 25'h004000, 49'h0000010000000, "one_times_one");
        run_op(25'(-24576), 25'(32768), 49'(-805306368), "neg1p5_times_2");
        run_op(MAXV, MINV, 49'h1_0000_0100_0000, "max_times_min");
        run_op(MINV, MINV, 49'h0_FFFF_FFFF_FFFF, "min_times_min_sat");
        run_op('0, MINV, 49'h0, "zero_times_min");
        run_op('1, '1, 49'h1, "neg1_times_neg1");

        // idle with start low: nothing moves
        prev = producto;
        repeat (5) @(negedge clk);
        check("idle_hold", 64'({producto, done, busy}), 64'({prev, 2'b00}));

        // reset in the middle of CALC aborts with no done pulse
        issue(25'h012345, 25'h00ABCD, 49'h0, 1'b0);
        void'(exp_q.pop_back());
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_producto", 64'(producto), 64'(0));
        done_n = 0;
        for (int n = 0; n < 30; n++) begin
            if (done) done_n++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(done_n), 64'(0));
        run_op(25'(-7), 25'h000123, ref_mul(25'(-7), 25'h000123), "after_abort");

        // start held high: one result every LAT+2 cycles, operands taken at acceptance
        last_done = -1;
        for (int k = 0; k < 3; k++) begin
            ra = pick();
            rb = pick();
            issue(ra, rb, ref_mul(ra, rb), 1'b1);
            wait_done(lat, busy_n, 1'b0);
            if (last_done >= 0) check("b2b_period", 64'(cyc - last_done), 64'(LAT + 2));
            last_done = cyc;
            finish_op("b2b", lat, busy_n);
        end
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            ra = pick();
            rb = pick();
            run_op(ra, rb, ref_mul(ra, rb), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplicador_secuencial.md
MULTIPLICADOR_SECUENCIAL -- requirements
Module: multiplicador_secuencial

Interface
REQ-001 Parameter cant_bits, default 25, operand width in Q(ent).(frac) signed fixed point: 1 sign + ent integer + frac fraction bits.
REQ-002 Parameter ent, default 10, integer bits per operand.
REQ-003 Parameter frac, default 14, fraction bits per operand; cant_bits SHALL equal ent+frac+1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-006 start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-007 a  input  cant_bits  signed multiplicand, two's complement.
REQ-008 b  input  cant_bits  signed multiplier, two's complement.
REQ-009 producto  output  2*ent+2*frac+1 (49 at defaults)  signed product in Q(2ent).(2frac) format, registered; feeds the downstream rounding/saturation stage directly.
REQ-010 done  output  1  one-cycle pulse marking producto newly valid.
REQ-011 busy  output  1  high while a multiplication is in progress.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, CALC, FIN.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL capture a and b into internal registers, clear the partial-product accumulator, set the bit counter to 0 and enter CALC.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE with all outputs holding.
REQ-015 In CALC, each cycle SHALL process one multiplier bit (radix-2 shift-add on operand magnitudes, or equivalent signed algorithm) and increment the counter.
REQ-016 After exactly cant_bits CALC cycles (counter reaching cant_bits-1 on the last), the block SHALL load producto and enter FIN on the same edge.
REQ-017 Latency: if start is sampled at edge E0, done SHALL be high during the cycle following edge E0+cant_bits (25 cycles at defaults) with producto valid in that same cycle.
REQ-018 FIN SHALL last exactly one cycle, then return to IDLE unconditionally; done=1 only in FIN.
REQ-019 busy SHALL be 1 in CALC and FIN, 0 in IDLE.
REQ-020 start asserted in CALC or FIN SHALL be ignored (no queuing); a, b changes during CALC/FIN SHALL not affect the result.
REQ-021 producto SHALL hold its value from FIN until the next FIN or reset.
REQ-022 producto SHALL equal the exact two's-complement product a*b, sign-extended to 49 bits, for all operand pairs except REQ-023.
REQ-023 Boundary: a = b = -2^(cant_bits-1) (exact product 2^48, unrepresentable) SHALL yield producto = 2^(2ent+2frac)-1 (0x0_FFFF_FFFF_FFFF at defaults).
REQ-024 Zero operand, sign combinations and maximum-magnitude operands SHALL incur the same fixed latency (no early termination).
REQ-025 Back-to-back: start held high continuously SHALL produce a new multiplication every cant_bits+2 cycles (re-accept in the IDLE cycle after FIN).

Reset
REQ-026 With reset=1 at a rising edge: state SHALL become IDLE, producto = 0, done = 0, busy = 0, counter and internal registers = 0.
REQ-027 reset SHALL take priority over start and over any in-progress CALC/FIN; an aborted multiplication SHALL produce no done pulse.
REQ-028 After reset deasserts, start SHALL be accepted on the first rising edge with reset=0.

Verification
REQ-029 a=0x004000 (1.0), b=0x004000, start one cycle -> after 25 cycles done=1 for exactly one cycle, producto=0x0000010000000 (2^28), busy high for 26 cycles.
REQ-030 a=-24576 (-1.5), b=32768 (2.0) -> producto=-805306368; a=0x7FFFFF... max(2^24-1), b=-2^24 -> producto=-2^48+2^24.
REQ-031 a=b=-2^24 -> producto=2^48-1 (saturated), done at normal latency.
REQ-032 reset asserted at CALC cycle 10 -> next cycle busy=0, producto=0, no done pulse; fresh start then completes correctly.
REQ-033 start held high across three operations with a/b changing mid-CALC -> done every 27 cycles, each producto matching operands captured at acceptance.
REQ-034 Random signed operand pairs (>=1000) compared to reference product -> zero mismatches, latency constant at 25.
